// File: rtl/cbus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// cbus_rr_arbiter
//   Round-robin arbiter that shares the single cached-bus master port among
//   NUM_INPUTS requesters (uncached I, ICache, uncached D, DCache). A grant is
//   held for a whole burst and released on oresp.ready & oresp.last. The
//   requester that just finished gets the lowest priority next time round.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   ireqs[i]        requests from the requesters
//   iresps[i]       responses steered back to the owner (zero for everyone else)
//   oreq / oresp    memory-side request / response
//   grant_idx       current owner (meaningful only while busy=1)
//   busy            a transaction is granted and in flight
//
// Optional feature (macro CBUS_ARB_STATS_EN)
//   grant_cnt[i]    32-bit wrapping count of grants to input i
//   stall_max       longest run of cycles any requester waited with valid=1
//                   and no grant, saturating at 0xFFFF
// -----------------------------------------------------------------------------

package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

`ifdef CBUS_ARB_STATS_EN
// Per-requester statistics: grant counter and current wait-run length.
module cbus_arb_stat_lane (
    input  logic        clk,
    input  logic        reset,
    input  logic        grant_ev_i,
    input  logic        wait_i,
    output logic [31:0] grant_cnt_o,
    output logic [15:0] stall_d_o
);
    logic [31:0] grant_cnt_q;
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = '0;
        if (wait_i) stall_d = (stall_q == 16'hFFFF) ? stall_q : stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt_q <= '0;
            stall_q     <= '0;
        end else begin
            if (grant_ev_i) grant_cnt_q <= grant_cnt_q + 32'd1;
            stall_q <= stall_d;
        end
    end

    assign grant_cnt_o = grant_cnt_q;
    assign stall_d_o   = stall_d;
endmodule
`endif

module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  cbus_req_t  [NUM_INPUTS-1:0] ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0] iresps,
    output cbus_req_t                   oreq,
    input  cbus_resp_t                  oresp,
    output logic [IDX_W-1:0]            grant_idx,
    output logic                        busy
`ifdef CBUS_ARB_STATS_EN
    ,
    output logic [NUM_INPUTS-1:0][31:0] grant_cnt,
    output logic [15:0]                 stall_max
`endif
);
    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] sel_q, ptr_q, sel_inc;
    logic             busy_q;

    logic             win_found;
    logic [IDX_W-1:0] win_idx, cidx;
    int               cand;

    // Scan ptr, ptr+1, ... wrapping modulo NUM_INPUTS; first valid wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cidx      = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_INPUTS) cand = cand - NUM_INPUTS;
            cidx = IDX_W'(cand);
            if (!win_found && ireqs[cidx].valid) begin
                win_found = 1'b1;
                win_idx   = cidx;
            end
        end
    end

    assign sel_inc = (int'(sel_q) == NUM_INPUTS - 1) ? '0 : sel_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        sel_q   <= win_idx;
                        state_q <= S_BUSY;
                        busy_q  <= 1'b1;
                    end
                end
                S_BUSY: begin
                    // Finished requester becomes lowest priority.
                    if (oresp.ready && oresp.last) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        ptr_q   <= sel_inc;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Pass-through only while BUSY; IDLE forwards nothing in either direction.
    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (state_q == S_BUSY) begin
            oreq          = ireqs[sel_q];
            iresps[sel_q] = oresp;
        end
    end

    assign busy      = busy_q;
    assign grant_idx = sel_q;

`ifdef CBUS_ARB_STATS_EN
    logic [NUM_INPUTS-1:0]       grant_ev, wait_v;
    logic [NUM_INPUTS-1:0][15:0] stall_d;
    logic [15:0]                 stall_max_q, stall_peak;

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lane
        assign grant_ev[g] = (state_q == S_IDLE) && win_found && (win_idx == IDX_W'(g));
        assign wait_v[g]   = ireqs[g].valid && !((state_q == S_BUSY) && (sel_q == IDX_W'(g)));

        cbus_arb_stat_lane u_lane (
            .clk         (clk),
            .reset       (reset),
            .grant_ev_i  (grant_ev[g]),
            .wait_i      (wait_v[g]),
            .grant_cnt_o (grant_cnt[g]),
            .stall_d_o   (stall_d[g])
        );
    end

    always_comb begin
        stall_peak = stall_max_q;
        for (int i = 0; i < NUM_INPUTS; i++)
            if (stall_d[i] > stall_peak) stall_peak = stall_d[i];
    end

    always_ff @(posedge clk) begin
        if (reset) stall_max_q <= '0;
        else       stall_max_q <= stall_peak;
    end

    assign stall_max = stall_max_q;
`endif

endmodule
